// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One operation takes WIDTH CALC cycles plus one FIX cycle for sign correction.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned W2   = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] opb_q, opb_d, rs_q, rs_d, hi_q, hi_d, lo_q, lo_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  logic             in_signed;
  logic [WIDTH-1:0] abs_rs, abs_rt;

  assign in_signed = ~op[0];
  assign abs_rs    = (in_signed && rs[WIDTH-1]) ? -rs : rs;
  assign abs_rt    = (in_signed && rt[WIDTH-1]) ? -rt : rt;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_new;
  logic [W2-1:0]    mul_next, div_next;

  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opb_q};
  assign div_diff = div_sh - {1'b0, opb_q};
  assign rem_new  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_next = {rem_new, acc_q[WIDTH-2:0], div_ge};

  logic             is_signed, res_dbz;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, res_hi, res_lo;

  assign is_signed = ~op_q[0];
  assign prod_fix  = (is_signed && (sa_q ^ sb_q)) ? -acc_q : acc_q;
  assign quo_fix   = (is_signed && (sa_q ^ sb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = (is_signed && sa_q) ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
  assign res_dbz   = op_q[1] && (opb_q == {WIDTH{1'b0}});

  always_comb begin
    res_hi = prod_fix[W2-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (op_q[1]) begin
      if (res_dbz) begin
        res_hi = rs_q;
        res_lo = {WIDTH{1'b1}};
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    opb_d   = opb_q;
    rs_d    = rs_q;
    acc_d   = acc_q;
    hi_d    = hi_we ? wdata : hi_q;
    lo_d    = lo_we ? wdata : lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          op_d    = op;
          sa_d    = in_signed & rs[WIDTH-1];
          sb_d    = in_signed & rt[WIDTH-1];
          opb_d   = abs_rt;
          rs_d    = rs;
          acc_d   = {{WIDTH{1'b0}}, abs_rs};
          cnt_d   = CntW'(WIDTH);
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (cancel) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          acc_d = op_q[1] ? div_next : mul_next;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!cancel) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
          dbz_d  = res_dbz;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opb_q   <= '0;
      rs_q    <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opb_q   <= opb_d;
      rs_q    <= rs_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
